// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one ALU among NREQ requesters with round-robin grants,
// issues each legal command, waits a command-dependent latency, then returns
// the captured result and flags to the granted requester.
module alu_share_ctrl #(
  parameter int unsigned DW      = 8,
  parameter int unsigned CW      = 4,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = $clog2(NREQ),
  parameter int unsigned LAT     = 2,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_opa,
  input  logic [NREQ*DW-1:0] req_opb,
  input  logic [NREQ*CW-1:0] req_cmd,
  input  logic [NREQ-1:0]    req_mode,
  input  logic [NREQ-1:0]    req_cin,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW+1:0]      rsp_res,
  output logic [5:0]         rsp_flags,
  output logic               rsp_illegal,
  output logic               alu_rst,
  output logic               alu_ce,
  output logic [1:0]         alu_inp_valid,
  output logic [DW-1:0]      alu_opa,
  output logic [DW-1:0]      alu_opb,
  output logic [CW-1:0]      alu_cmd,
  output logic               alu_mode,
  output logic               alu_cin,
  input  logic [DW+1:0]      alu_res,
  input  logic               alu_cout,
  input  logic               alu_oflow,
  input  logic               alu_g,
  input  logic               alu_e,
  input  logic               alu_l,
  input  logic               alu_err,
  output logic               busy
);

  localparam int unsigned MAXLAT = (LAT > MUL_LAT) ? LAT : MUL_LAT;
  localparam int unsigned CNTW   = $clog2(MAXLAT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t          state, state_d;
  logic [IDW-1:0]  ptr, ptr_d;
  logic [CNTW-1:0] cnt, cnt_d;
  logic [DW-1:0]   opa_d, opb_d;
  logic [CW-1:0]   cmd_d;
  logic            mode_d, cin_d, ce_d, rv_d, ill_d, busy_d;
  logic [1:0]      iv_d;
  logic [IDW-1:0]  id_d;
  logic [DW+1:0]   res_d;
  logic [5:0]      flags_d;

  logic [DW-1:0]   opa_arr [NREQ];
  logic [DW-1:0]   opb_arr [NREQ];
  logic [CW-1:0]   cmd_arr [NREQ];
  logic            gnt_found, grant, legal, is_mul;
  logic [IDW-1:0]  gnt_id;
  int unsigned     idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign opa_arr[gi] = req_opa[gi*DW +: DW];
    assign opb_arr[gi] = req_opb[gi*DW +: DW];
    assign cmd_arr[gi] = req_cmd[gi*CW +: CW];
  end

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    idx       = 0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      if (!gnt_found && req_valid[IDW'(idx)]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

  assign grant  = (state == IDLE) && !alu_rst && gnt_found;
  assign legal  = req_mode[gnt_id] ? (cmd_arr[gnt_id] <= CW'(10)) : (cmd_arr[gnt_id] <= CW'(13));
  assign is_mul = alu_mode && ((alu_cmd == CW'(9)) || (alu_cmd == CW'(10)));

  // One-hot grant pulse; the request is consumed in the cycle it is shown.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_id] = 1'b1;
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    opa_d   = alu_opa;
    opb_d   = alu_opb;
    cmd_d   = alu_cmd;
    mode_d  = alu_mode;
    cin_d   = alu_cin;
    id_d    = rsp_id;
    ce_d    = 1'b0;
    iv_d    = 2'b00;
    rv_d    = rsp_valid;
    res_d   = rsp_res;
    flags_d = rsp_flags;
    ill_d   = rsp_illegal;
    case (state)
      IDLE: begin
        if (grant) begin
          id_d  = gnt_id;
          ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
          if (legal) begin
            opa_d   = opa_arr[gnt_id];
            opb_d   = opb_arr[gnt_id];
            cmd_d   = cmd_arr[gnt_id];
            mode_d  = req_mode[gnt_id];
            cin_d   = req_cin[gnt_id];
            ce_d    = 1'b1;
            iv_d    = 2'b11;
            ill_d   = 1'b0;
            state_d = ISSUE;
          end else begin
            rv_d    = 1'b1;
            ill_d   = 1'b1;
            res_d   = '0;
            flags_d = '0;
            state_d = RESP;
          end
        end
      end
      ISSUE: begin
        ce_d    = 1'b1;
        cnt_d   = is_mul ? CNTW'(MUL_LAT - 1) : CNTW'(LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          rv_d    = 1'b1;
          res_d   = alu_res;
          // Undriven or unknown flags read as 0.
          flags_d = {alu_cout === 1'b1, alu_oflow === 1'b1, alu_g === 1'b1,
                     alu_e === 1'b1, alu_l === 1'b1, alu_err === 1'b1};
          state_d = RESP;
        end else begin
          ce_d  = 1'b1;
          cnt_d = cnt - CNTW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; alu_rst trails reset by one cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      alu_rst       <= 1'b1;
      alu_ce        <= 1'b0;
      alu_inp_valid <= 2'b00;
      alu_opa       <= '0;
      alu_opb       <= '0;
      alu_cmd       <= '0;
      alu_mode      <= 1'b0;
      alu_cin       <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_res       <= '0;
      rsp_flags     <= '0;
      rsp_illegal   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      ptr           <= ptr_d;
      cnt           <= cnt_d;
      alu_rst       <= 1'b0;
      alu_ce        <= ce_d;
      alu_inp_valid <= iv_d;
      alu_opa       <= opa_d;
      alu_opb       <= opb_d;
      alu_cmd       <= cmd_d;
      alu_mode      <= mode_d;
      alu_cin       <= cin_d;
      rsp_valid     <= rv_d;
      rsp_id        <= id_d;
      rsp_res       <= res_d;
      rsp_flags     <= flags_d;
      rsp_illegal   <= ill_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: scoreboard bench for alu_share_ctrl with a pipelined ALU model.
module tb_alu_share_ctrl;

  localparam int LAT     = 2;
  localparam int MUL_LAT = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  req_valid, req_ready, req_mode, req_cin;
  logic [31:0] req_opa, req_opb;
  logic [15:0] req_cmd;
  logic        rsp_valid, rsp_ready, rsp_illegal;
  logic [1:0]  rsp_id;
  logic [9:0]  rsp_res;
  logic [5:0]  rsp_flags;
  logic        alu_rst, alu_ce, alu_mode, alu_cin, busy;
  logic [1:0]  alu_inp_valid;
  logic [7:0]  alu_opa, alu_opb;
  logic [3:0]  alu_cmd;
  logic [9:0]  alu_res;
  logic        alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err;

  alu_share_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
    .req_mode(req_mode), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal),
    .alu_rst(alu_rst), .alu_ce(alu_ce), .alu_inp_valid(alu_inp_valid),
    .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
    .alu_mode(alu_mode), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_oflow(alu_oflow),
    .alu_g(alu_g), .alu_e(alu_e), .alu_l(alu_l), .alu_err(alu_err),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [18:0] q[$];  // {id, res, flags, illegal}

  // ALU model: single ops visible LAT cycles after issue, mul ops MUL_LAT.
  typedef struct packed { logic [9:0] res; logic [5:0] fl; } aout_t;
  aout_t st1, st2, st3;
  logic  mul_op;

  function automatic aout_t alu_model(logic m, logic [3:0] c, logic [7:0] a, logic [7:0] b);
    aout_t r;
    logic [8:0] s;
    r = '0;
    s = '0;
    if (m) begin
      case (c)
        4'd0: begin s = {1'b0, a} + {1'b0, b}; r.res = {1'b0, s}; r.fl[5] = s[8]; end
        4'd8: r.fl[3:1] = {a > b, a == b, a < b};
        4'd9: r.res = ({2'b00, a} + 10'd1) * ({2'b00, b} + 10'd1);
        4'd10: r.res = ({2'b00, a} << 1) * {2'b00, b};
        default: ;
      endcase
    end else begin
      case (c)
        4'd0: r.res = {2'b00, a & b};
        4'd2: r.res = {2'b00, a | b};
        4'd4: r.res = {2'b00, a ^ b};
        default: ;
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge CLK) begin
    if (alu_rst) begin
      st1 <= '0; st2 <= '0; st3 <= '0; mul_op <= 1'b0;
    end else if (alu_ce) begin
      if (alu_inp_valid == 2'b11) begin
        st1    <= alu_model(alu_mode, alu_cmd, alu_opa, alu_opb);
        mul_op <= alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10);
      end
      st2 <= st1;
      st3 <= st2;
    end
  end

  assign alu_res = mul_op ? st3.res : st2.res;
  assign {alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err} = mul_op ? st3.fl : st2.fl;

  task automatic drive_req(input logic [1:0] id, input logic m, input logic [3:0] c,
                           input logic [7:0] a, input logic [7:0] b);
    req_opa[{id, 3'b000} +: 8] = a;
    req_opb[{id, 3'b000} +: 8] = b;
    req_cmd[{id, 2'b00} +: 4]  = c;
    req_mode[id]  = m;
    req_cin[id]   = 1'b0;
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_grant(input logic [1:0] id, output int g, output bit ok);
    ok = 1'b0;
    g  = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge CLK);
      if (req_ready[id] === 1'b1) begin ok = 1'b1; g = cyc; end
    end
    @(posedge CLK); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output int r, output int niss, output bit ok);
    ok   = 1'b0;
    r    = 0;
    niss = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge CLK);
      if (alu_inp_valid === 2'b11) niss++;
      if (rsp_valid === 1'b1) begin ok = 1'b1; r = cyc; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({busy, rsp_valid, alu_rst, alu_ce, alu_inp_valid, req_ready} !== 10'b0010000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b",
               {busy, rsp_valid, alu_rst, alu_ce, alu_inp_valid, req_ready}, 10'b0010000000);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (alu_rst !== 1'b1) begin errors++; $display("FAIL reset_alu_rst_hold: got %b want 1", alu_rst); end
    @(negedge CLK);
    checks++;
    if ({alu_rst, busy} !== 2'b00) begin errors++; $display("FAIL reset_release: got %b want 00", {alu_rst, busy}); end
    @(posedge CLK); #1;
  endtask

  task automatic test_single_add();
    int g, r, n;
    bit ok;
    logic [18:0] e;
    rsp_ready = 1'b1;
    drive_req(2'd0, 1'b1, 4'd0, 8'hFF, 8'h01);
    q.push_back({2'd0, 10'h100, 6'b100000, 1'b0});
    wait_grant(2'd0, g, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL add_grant: got no req_ready[0] want pulse"); end
    wait_rsp(r, n, ok);
    checks++;
    if (!ok || (r - g) != 1 + LAT + 1) begin
      errors++; $display("FAIL add_latency: got %0d want %0d (seen %0d)", r - g, 1 + LAT + 1, ok);
    end
    checks++;
    if (n != 1) begin errors++; $display("FAIL add_issue_count: got %0d want 1", n); end
    e = '1;
    if (q.size() != 0) e = q.pop_front();
    checks++;
    if ({rsp_id, rsp_res, rsp_flags, rsp_illegal} !== e) begin
      errors++; $display("FAIL add_rsp: got %h want %h", {rsp_id, rsp_res, rsp_flags, rsp_illegal}, e);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_multiply();
    int g, r, n;
    bit ok;
    logic [18:0] e;
    drive_req(2'd2, 1'b1, 4'd9, 8'd3, 8'd4);
    q.push_back({2'd2, 10'd20, 6'b000000, 1'b0});
    wait_grant(2'd2, g, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mul_grant: got no req_ready[2] want pulse"); end
    wait_rsp(r, n, ok);
    checks++;
    if (!ok || (r - g) != 1 + MUL_LAT + 1) begin
      errors++; $display("FAIL mul_latency: got %0d want %0d (seen %0d)", r - g, 1 + MUL_LAT + 1, ok);
    end
    checks++;
    if (n != 1) begin errors++; $display("FAIL mul_issue_count: got %0d want 1", n); end
    e = '1;
    if (q.size() != 0) e = q.pop_front();
    checks++;
    if ({rsp_id, rsp_res, rsp_flags, rsp_illegal} !== e) begin
      errors++; $display("FAIL mul_rsp: got %h want %h", {rsp_id, rsp_res, rsp_flags, rsp_illegal}, e);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_compare_logic();
    int g, r, n;
    bit ok;
    logic [18:0] e;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) begin
        drive_req(2'd3, 1'b1, 4'd8, 8'd5, 8'd9);
        q.push_back({2'd3, 10'h000, 6'b000010, 1'b0});
      end else begin
        drive_req(2'd3, 1'b0, 4'd4, 8'hF0, 8'h3C);
        q.push_back({2'd3, 10'h0CC, 6'b000000, 1'b0});
      end
      wait_grant(2'd3, g, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL cmp_grant%0d: got no req_ready[3] want pulse", t); end
      wait_rsp(r, n, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL cmp_rsp_seen%0d: got no rsp_valid want 1", t); end
      e = '1;
      if (q.size() != 0) e = q.pop_front();
      checks++;
      if ({rsp_id, rsp_res, rsp_flags, rsp_illegal} !== e) begin
        errors++; $display("FAIL cmp_rsp%0d: got %h want %h", t, {rsp_id, rsp_res, rsp_flags, rsp_illegal}, e);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] ra [4];
    logic [7:0] rb [4];
    logic [8:0] s;
    logic [3:0] exp_oh;
    logic [18:0] e;
    int ng, got, k;
    for (int i = 0; i < 4; i++) begin
      ra[i] = 8'(60 * i + 200);
      rb[i] = 8'(7 * i + 30);
      drive_req(2'(i), 1'b1, 4'd0, ra[i], rb[i]);
    end
    rsp_ready = 1'b1;
    ng  = 0;
    got = 0;
    for (int n = 0; n < 300 && got < 8; n++) begin
      @(negedge CLK);
      if (req_ready !== 4'b0000 && ng < 8) begin
        k      = ng % 4;
        exp_oh = 4'(1 << k);
        checks++;
        if (req_ready !== exp_oh) begin
          errors++; $display("FAIL rr_grant%0d: got %b want %b", ng, req_ready, exp_oh);
        end
        s = {1'b0, ra[k]} + {1'b0, rb[k]};
        q.push_back({2'(k), {1'b0, s}, {s[8], 5'b00000}, 1'b0});
        ng++;
        if (ng == 8) begin @(posedge CLK); #1; req_valid = '0; end
      end
      if (rsp_valid === 1'b1) begin
        e = '1;
        if (q.size() != 0) e = q.pop_front();
        checks++;
        if ({rsp_id, rsp_res, rsp_flags, rsp_illegal} !== e) begin
          errors++; $display("FAIL rr_rsp%0d: got %h want %h", got, {rsp_id, rsp_res, rsp_flags, rsp_illegal}, e);
        end
        got++;
      end
    end
    checks++;
    if (got != 8 || ng != 8) begin errors++; $display("FAIL rr_count: got %0d/%0d want 8/8", ng, got); end
    req_valid = '0;
    @(posedge CLK); #1;
  endtask

  task automatic test_illegal_backpressure();
    int g, r, n;
    bit ok;
    logic [18:0] e;
    logic [19:0] snap;
    rsp_ready = 1'b0;
    drive_req(2'd1, 1'b1, 4'd12, 8'd1, 8'd2);
    q.push_back({2'd1, 10'h000, 6'b000000, 1'b1});
    wait_grant(2'd1, g, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ill_grant: got no req_ready[1] want pulse"); end
    wait_rsp(r, n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ill_rsp_seen: got no rsp_valid want 1"); end
    checks++;
    if (n != 0) begin errors++; $display("FAIL ill_issue_count: got %0d want 0", n); end
    e = '1;
    if (q.size() != 0) e = q.pop_front();
    checks++;
    if ({rsp_id, rsp_res, rsp_flags, rsp_illegal} !== e) begin
      errors++; $display("FAIL ill_rsp: got %h want %h", {rsp_id, rsp_res, rsp_flags, rsp_illegal}, e);
    end
    snap = {1'b1, e};
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      checks++;
      if ({rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_illegal, alu_inp_valid, alu_ce} !== {snap, 3'b000}) begin
        errors++;
        $display("FAIL ill_hold%0d: got %h want %h", k,
                 {rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_illegal, alu_inp_valid, alu_ce}, {snap, 3'b000});
      end
    end
    @(posedge CLK); #1;
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if ({busy, rsp_valid} !== 2'b00) begin errors++; $display("FAIL ill_idle: got %b want 00", {busy, rsp_valid}); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_midop();
    int g, r, n, c0;
    bit ok;
    logic [18:0] e;
    rsp_ready = 1'b1;
    drive_req(2'd1, 1'b1, 4'd0, 8'h12, 8'h34);
    q.push_back({2'd1, 10'h046, 6'b000000, 1'b0});
    wait_grant(2'd1, g, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_grant: got no req_ready[1] want pulse"); end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    q.delete();
    drive_req(2'd3, 1'b0, 4'd0, 8'hF0, 8'h3C);
    q.push_back({2'd3, 10'h030, 6'b000000, 1'b0});
    @(negedge CLK);
    c0 = cyc;
    checks++;
    if ({busy, rsp_valid, alu_rst, req_ready} !== 7'b0010000) begin
      errors++; $display("FAIL rst_midop_state: got %b want %b", {busy, rsp_valid, alu_rst, req_ready}, 7'b0010000);
    end
    wait_grant(2'd3, g, ok);
    checks++;
    if (!ok || g != c0 + 1) begin errors++; $display("FAIL rst_regrant: got cycle %0d want %0d", g, c0 + 1); end
    wait_rsp(r, n, ok);
    checks++;
    if (!ok || (r - g) != 1 + LAT + 1) begin
      errors++; $display("FAIL rst_latency: got %0d want %0d", r - g, 1 + LAT + 1);
    end
    e = '1;
    if (q.size() != 0) e = q.pop_front();
    checks++;
    if ({rsp_id, rsp_res, rsp_flags, rsp_illegal} !== e) begin
      errors++; $display("FAIL rst_rsp: got %h want %h", {rsp_id, rsp_res, rsp_flags, rsp_illegal}, e);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    req_valid = '0;
    req_opa   = '0;
    req_opb   = '0;
    req_cmd   = '0;
    req_mode  = '0;
    req_cin   = '0;
    rsp_ready = 1'b0;
    RST       = 1'b0;
    test_reset();
    test_single_add();
    test_multiply();
    test_compare_logic();
    test_round_robin();
    test_illegal_backpressure();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
